led_blink_arbiter: RTL and testbench
====================================

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the LED.
REQ-002 SHALL have parameter TICK_DIV, default 100000, CLK cycles per tick (1 ms at 100 MHz).
REQ-003 SHALL have parameter ON_TICKS, default 250, LED-on duration per blink, in ticks.
REQ-004 SHALL have parameter OFF_TICKS, default 250, LED-off duration per blink, in ticks.
REQ-005 SHALL have parameter GAP_TICKS, default 1000, dark pause after each service, in ticks.
REQ-006 SHALL constrain all four timing parameters to be >= 1.
REQ-007 SHALL have port CLK, input, 1 bit, sole clock; all logic is on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit, synchronous, active-high reset.
REQ-009 SHALL have port REQ, input, NREQ bits, per-requester blink request level.
REQ-010 SHALL have port COUNT, input, NREQ*4 bits, blink count for requester i at bits [4i+3:4i].
REQ-011 SHALL have port GNT, output, NREQ bits, one-hot grant; all zero when no requester is in service.
REQ-012 SHALL have port DONE, output, NREQ bits, one-cycle completion pulse per requester.
REQ-013 SHALL have port LED, output, 1 bit, the shared LED drive, registered.
REQ-014 SHALL have port BUSY, output, 1 bit, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, ON, OFF and GAP; all outputs SHALL be registered.
REQ-016 SHALL run a prescaler counting 0..TICK_DIV-1, restarting at 0 on every state entry, so the state occupies exactly N*TICK_DIV cycles for an N-tick duration.
REQ-017 In IDLE with any REQ bit high at edge t, SHALL select one requester round-robin, starting from the index after the last granted one.
REQ-018 On that selection, SHALL drive GNT one-hot, LED=1 and enter ON at edge t+1 (one-cycle latency).
REQ-019 On grant, SHALL latch the selected COUNT slice; COUNT=0 SHALL mean 16 blinks.
REQ-020 SHALL leave the latched count and the grant unaffected by later COUNT changes or by REQ deassertion during service.
REQ-021 In ON, after ON_TICKS ticks, SHALL drive LED=0 and enter OFF.
REQ-022 In OFF, after OFF_TICKS ticks, SHALL decrement the remaining count; if it was greater than 1, SHALL drive LED=1 and return to ON.
REQ-023 In OFF, if the remaining count was 1, SHALL enter GAP, clear GNT and pulse DONE[granted] for exactly one cycle, all on the same edge.
REQ-024 In GAP, after GAP_TICKS ticks, SHALL enter IDLE with LED=0.
REQ-025 SHALL keep LED=0 throughout GAP and IDLE.
REQ-026 SHALL ignore REQ while BUSY is high.
REQ-027 A requester still holding REQ after its DONE SHALL be eligible again, but at lowest round-robin priority.
REQ-028 With several REQ bits high in IDLE, SHALL grant only one requester; at most one GNT bit is ever high.
REQ-029 SHALL never assert DONE for a requester that was not granted.

Reset
REQ-030 While RST is high at an edge: state IDLE; LED, GNT, DONE and BUSY 0; prescaler and remaining count 0.
REQ-031 After reset, the round-robin pointer SHALL give requester 0 first priority.
REQ-032 Reset mid-service SHALL abort it: LED=0 on that edge and no DONE pulse.

Verification (TICK_DIV=2, ON_TICKS=3, OFF_TICKS=2, GAP_TICKS=4, NREQ=4)
REQ-033 RST high 3 cycles with REQ=4'b1111 -> LED/GNT/DONE/BUSY 0 throughout; first edge after release gives GNT=4'b0001.
REQ-034 REQ[1]=1, COUNT[1]=2 -> GNT=4'b0010 next edge; LED high 6, low 4, high 6, low 4 cycles; DONE[1] 1-cycle pulse as GNT clears; BUSY stays high 8 more cycles, then IDLE.
REQ-035 REQ=4'b1111 held, all COUNT=1 -> grant order 0,1,2,3,0; each service lasts 10 cycles, followed by 8 GAP cycles.
REQ-036 REQ[2]=1, COUNT[2]=0 -> exactly 16 LED high pulses before DONE[2].
REQ-037 REQ[0] dropped after 2 cycles of ON with COUNT=3 -> all 3 blinks complete and DONE[0] pulses.
REQ-038 RST asserted during ON -> LED, GNT and BUSY 0 on that edge; no DONE; next grant goes to requester 0.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that lends one shared LED to NREQ requesters.
// Each granted requester gets COUNT on/off blinks, followed by a dark gap.
module led_blink_arbiter #(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 100000,
  parameter int ON_TICKS  = 250,
  parameter int OFF_TICKS = 250,
  parameter int GAP_TICKS = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*4-1:0] COUNT,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic              LED,
  output logic              BUSY
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (ON_TICKS > OFF_TICKS) ?
                        ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                        ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

  generate
    if ((TICK_DIV < 1) || (ON_TICKS < 1) || (OFF_TICKS < 1) || (GAP_TICKS < 1)) begin : g_bad_params
      $error("led_blink_arbiter: all timing parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   presc_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [4:0]      remain_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic            led_r;
  logic            busy_r;

  logic            any_req_s;
  logic [IW-1:0]   sel_idx_s;
  logic [IW:0]     idx_s;
  logic [NREQ*4-1:0] count_sh_s;
  logic [3:0]      sel_raw_s;
  logic [4:0]      sel_cnt_s;
  logic [IW-1:0]   next_ptr_s;
  logic [TW-1:0]   dur_last_s;
  logic            tick_s;
  logic            expire_s;

  // Round-robin pick: scan from rr_ptr_r upward, lowest offset wins.
  always_comb begin
    any_req_s = 1'b0;
    sel_idx_s = '0;
    idx_s     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(NREQ)) begin
        idx_s = idx_s - (IW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (REQ[idx_s[IW-1:0]]) begin
        any_req_s = 1'b1;
        sel_idx_s = idx_s[IW-1:0];
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Blink count of the selected requester; a zero field means sixteen blinks.
  always_comb begin
    count_sh_s = COUNT >> {sel_idx_s, 2'b00};
    sel_raw_s  = count_sh_s[3:0];
    if (sel_raw_s == 4'd0) begin
      sel_cnt_s = 5'd16;
    end else begin
      sel_cnt_s = {1'b0, sel_raw_s};
    end
    if (sel_idx_s == IW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = sel_idx_s + IW'(1);
    end
  end

  // Duration of the current state and end-of-state detection.
  always_comb begin
    case (state_r)
      ST_ON:   dur_last_s = ON_LAST;
      ST_OFF:  dur_last_s = OFF_LAST;
      ST_GAP:  dur_last_s = GAP_LAST;
      default: dur_last_s = '0;
    endcase
    tick_s   = (presc_r == PRESC_LAST);
    expire_s = tick_s && (tick_cnt_r == dur_last_s);
  end

  // Main FSM; every output is a register updated on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      presc_r    <= '0;
      tick_cnt_r <= '0;
      remain_r   <= 5'd0;
      rr_ptr_r   <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= '0;
      if (state_r != ST_IDLE) begin
        if (tick_s) begin
          presc_r    <= '0;
          tick_cnt_r <= tick_cnt_r + TW'(1);
        end else begin
          presc_r <= presc_r + PW'(1);
        end
      end
      // Transitions below reset the timebase so each state starts from zero.
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r    <= ST_ON;
            gnt_r      <= NREQ'(1'b1) << sel_idx_s;
            led_r      <= 1'b1;
            busy_r     <= 1'b1;
            remain_r   <= sel_cnt_s;
            rr_ptr_r   <= next_ptr_s;
            presc_r    <= '0;
            tick_cnt_r <= '0;
          end
        end
        ST_ON: begin
          if (expire_s) begin
            state_r    <= ST_OFF;
            led_r      <= 1'b0;
            presc_r    <= '0;
            tick_cnt_r <= '0;
          end
        end
        ST_OFF: begin
          if (expire_s) begin
            presc_r    <= '0;
            tick_cnt_r <= '0;
            if (remain_r > 5'd1) begin
              state_r  <= ST_ON;
              remain_r <= remain_r - 5'd1;
              led_r    <= 1'b1;
            end else begin
              state_r  <= ST_GAP;
              remain_r <= 5'd0;
              gnt_r    <= '0;
              done_r   <= gnt_r;
            end
          end
        end
        ST_GAP: begin
          if (expire_s) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            led_r      <= 1'b0;
            presc_r    <= '0;
            tick_cnt_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt_r      <= '0;
          led_r      <= 1'b0;
          busy_r     <= 1'b0;
          presc_r    <= '0;
          tick_cnt_r <= '0;
        end
      endcase
    end
  end

  assign GNT  = gnt_r;
  assign DONE = done_r;
  assign LED  = led_r;
  assign BUSY = busy_r;

endmodule

// Protocol checker for the arbiter outputs: grant exclusivity and DONE legality.
module led_blink_arbiter_checker #(
  parameter int NREQ = 4
) (
  input logic            CLK,
  input logic            RST,
  input logic [NREQ-1:0] GNT,
  input logic [NREQ-1:0] DONE,
  input logic            LED,
  input logic            BUSY
);

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
  a_done_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(DONE));
  a_led_busy: assert property (@(posedge CLK) disable iff (RST) LED |-> BUSY);
  a_done_granted: assert property (@(posedge CLK) disable iff (RST)
                                   (DONE & ~$past(GNT)) == '0);

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: a table of services, each expanded into a
// per-cycle expected trace that is checked against the DUT at every falling edge.
module tb_led_blink_arbiter;

  localparam int NREQ      = 4;
  localparam int TICK_DIV  = 2;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int GAP_TICKS = 4;
  localparam int ON_C      = ON_TICKS * TICK_DIV;
  localparam int OFF_C     = OFF_TICKS * TICK_DIV;
  localparam int GAP_C     = GAP_TICKS * TICK_DIV;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [15:0] COUNT;
  logic [3:0]  GNT;
  logic [3:0]  DONE;
  logic        LED;
  logic        BUSY;

  typedef struct packed {
    logic       led;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
  } obs_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] count;
    logic [15:0] count_mid;
    int          drop_after;
    logic [3:0]  exp_gnt;
    int          blinks;
  } vec_t;

  obs_t exp_q[$];
  vec_t tbl[13];
  int   n_vec;
  int   n_err;

  led_blink_arbiter #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .ON_TICKS(ON_TICKS),
    .OFF_TICKS(OFF_TICKS), .GAP_TICKS(GAP_TICKS)
  ) u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .COUNT(COUNT),
    .GNT(GNT), .DONE(DONE), .LED(LED), .BUSY(BUSY)
  );

  led_blink_arbiter_checker #(.NREQ(NREQ)) u_chk (
    .CLK(CLK), .RST(RST), .GNT(GNT), .DONE(DONE), .LED(LED), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected samples pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic push_obs(input logic led, input logic [3:0] gnt,
                          input logic [3:0] done, input logic busy, input int n);
    obs_t o;
    o.led  = led;
    o.gnt  = gnt;
    o.done = done;
    o.busy = busy;
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  // Expected trace of one service, starting with the sample after the grant edge
  // and ending with the single IDLE sample after the gap.
  task automatic push_service(input logic [3:0] g, input int blinks);
    for (int b = 0; b < blinks; b++) begin
      push_obs(1'b1, g, 4'b0000, 1'b1, ON_C);
      push_obs(1'b0, g, 4'b0000, 1'b1, OFF_C);
    end
    push_obs(1'b0, 4'b0000, g, 1'b1, 1);
    push_obs(1'b0, 4'b0000, 4'b0000, 1'b1, GAP_C - 1);
    push_obs(1'b0, 4'b0000, 4'b0000, 1'b0, 1);
  endtask

  task automatic cycle();
    obs_t e;
    @(negedge CLK);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL underflow: sample %0d has no expected value", n_vec);
    end else begin
      e = exp_q.pop_front();
      if ({LED, GNT, DONE, BUSY} !== e) begin
        n_err++;
        $display("FAIL sample_%0d: got led=%b gnt=%b done=%b busy=%b, want led=%b gnt=%b done=%b busy=%b",
                 n_vec, LED, GNT, DONE, BUSY, e.led, e.gnt, e.done, e.busy);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    cyc   = 0;
    REQ   = v.req;
    COUNT = v.count;
    push_service(v.exp_gnt, v.blinks);
    while (exp_q.size() > 0) begin
      cycle();
      cyc++;
      if (cyc == 1) COUNT = v.count_mid;
      if ((v.drop_after != 0) && (cyc == v.drop_after)) REQ = 4'b0000;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // req, count, count after grant, drop REQ after N cycles (0 = hold), grant, blinks
    tbl[0]  = '{4'b1111, 16'h1111, 16'h1111, 0, 4'b0001, 1};
    tbl[1]  = '{4'b1111, 16'h1111, 16'h1111, 0, 4'b0010, 1};
    tbl[2]  = '{4'b1111, 16'h1111, 16'h1111, 0, 4'b0100, 1};
    tbl[3]  = '{4'b1111, 16'h1111, 16'h1111, 0, 4'b1000, 1};
    tbl[4]  = '{4'b1111, 16'h1111, 16'h1111, 1, 4'b0001, 1};
    tbl[5]  = '{4'b0010, 16'h0020, 16'h0020, 1, 4'b0010, 2};
    tbl[6]  = '{4'b0100, 16'h0000, 16'h0000, 1, 4'b0100, 16};
    tbl[7]  = '{4'b0001, 16'h0003, 16'h0003, 2, 4'b0001, 3};
    tbl[8]  = '{4'b1000, 16'h2000, 16'h5000, 1, 4'b1000, 2};
    tbl[9]  = '{4'b0110, 16'h0110, 16'h0110, 1, 4'b0010, 1};
    tbl[10] = '{4'b1001, 16'h1001, 16'h1001, 1, 4'b1000, 1};
    tbl[11] = '{4'b1001, 16'h1001, 16'h1001, 1, 4'b0001, 1};
    tbl[12] = '{4'b0001, 16'h0001, 16'h0001, 1, 4'b0001, 1};

    // Reset held three cycles with every requester asking.
    RST   = 1'b1;
    REQ   = 4'b1111;
    COUNT = 16'h1111;
    push_obs(1'b0, 4'b0000, 4'b0000, 1'b0, 3);
    for (int i = 0; i < 3; i++) cycle();
    RST = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Reset in the middle of an ON phase aborts the service with no DONE.
    REQ   = 4'b0100;
    COUNT = 16'h0100;
    push_obs(1'b1, 4'b0100, 4'b0000, 1'b1, 3);
    for (int i = 0; i < 3; i++) cycle();
    RST = 1'b1;
    push_obs(1'b0, 4'b0000, 4'b0000, 1'b0, 1);
    cycle();
    RST = 1'b0;
    REQ = 4'b0000;
    push_obs(1'b0, 4'b0000, 4'b0000, 1'b0, 2);
    for (int i = 0; i < 2; i++) cycle();
    run_vec('{4'b1111, 16'h1111, 16'h1111, 1, 4'b0001, 1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
